dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the CPU data port: multi-cycle word memory with
//   valid/ready request and one-cycle response strobe. Replaces the zero-wait
//   dmem on the MEM stage; busy drives the pipeline stall enables.
//   Serves one outstanding request; latency is set by parameter.
// PARAMETERS
//   WIDTH    2   log2 bytes per word; low WIDTH address bits must be zero
//   DEPTH    10  log2 number of words stored (1024 words)
//   LATENCY  3   cycles from request accept to resp_valid, legal range 1..15
// PORTS
//   clk         input   1   clock, rising edge
//   reset       input   1   asynchronous, active-high
//   req_valid   input   1   request present on req_* this cycle
//   req_ready   output  1   responder can accept a request this cycle
//   req_write   input   1   1 = store word, 0 = load word
//   req_addr    input   32  byte address
//   req_wdata   input   32  store data
//   resp_valid  output  1   one-cycle strobe: access complete
//   resp_rdata  output  32  load data, valid with resp_valid, else 0
//   resp_err    output  1   misaligned or out-of-range access, valid with resp_valid
//   busy        output  1   request in flight; CPU holds pc/if_id/id_ex/ex_mem
// BEHAVIOUR
//   Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0,
//     resp_err=0, busy=0. Memory array is not cleared by reset.
//   Accept: req_valid & req_ready at a rising edge latches write/addr/wdata.
//   FSM:
//     IDLE: req_ready=1, busy=0. On accept, cnt<=LATENCY-1, go WAIT.
//       If LATENCY==1, go RESP directly.
//     WAIT: req_ready=0, busy=1. cnt decrements each cycle; at cnt==1, go RESP.
//     RESP: resp_valid=1 for exactly one cycle, busy=1, req_ready=0.
//       Next state is IDLE unconditionally.
//   Timing: accept at edge N, so resp_valid is high in cycle N+LATENCY.
//     The next accept is possible at edge N+LATENCY+1.
//     Peak throughput is one access per LATENCY+1 cycles.
//   Access: index = addr[WIDTH+DEPTH-1:WIDTH].
//     Store commits on the edge entering RESP. Load data is registered on
//     that same edge.
//   Error: addr[WIDTH-1:0]!=0, or addr[31:WIDTH+DEPTH]!=0, gives resp_err=1
//     and resp_rdata=0. No store is performed.
//   Store response: resp_rdata=0, resp_err=0 unless in error.
//   req_* inputs are ignored outside IDLE. Inputs need not be held after accept.
//   Load after store to the same address returns the new data; no forwarding
//     is needed since accesses are serialized.
//   Reset mid-operation: the pending request is abandoned. A store is not
//     committed unless the RESP edge already occurred. The FSM returns to IDLE
//     and outputs take their reset values.
//   Counter width: 4 bits.
// TESTING
//   Reset, then idle: req_ready=1, busy=0, resp_valid=0 on every cycle.
//   Store 0xDEADBEEF to 0x10 at edge 0 (LATENCY=3):
//     busy=1 in cycles 1..3, resp_valid=1 only in cycle 3, rdata=0, err=0.
//   Load 0x10 after that store: resp_valid 3 cycles after accept,
//     resp_rdata=0xDEADBEEF.
//   Back-to-back requests with req_valid held high:
//     second accept occurs exactly 4 edges after the first.
//   Load 0x12 (misaligned) and load 0x00001000 (out of range, DEPTH=10):
//     resp_err=1, rdata=0. A store to 0x12 leaves word 0x10 unchanged.
//   Store 0x1234 to 0x20, assert reset in the WAIT state, then load 0x20:
//     old contents returned. FSM is in IDLE one cycle after reset deasserts.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle word memory behind a valid/ready request port.
// Serves one request at a time and strobes resp_valid once per access.
module dmem_responder #(
  parameter int WIDTH   = 2,
  parameter int DEPTH   = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);
  localparam logic [31:0] ALIGN_MASK = (32'd1 << WIDTH) - 32'd1;

  state_t state, state_n;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [2**DEPTH];

  logic             accept;
  logic             fire;
  logic             cur_write;
  logic [31:0]      cur_addr;
  logic [31:0]      cur_wdata;
  logic             cur_err;
  logic [DEPTH-1:0] idx;

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    busy       = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = (LATENCY == 1) ? RESP : WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd1) state_n = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign accept = req_valid & req_ready;
  assign fire   = (state_n == RESP) && (state != RESP);

  // With LATENCY==1 the access happens on the accept edge itself
  always_comb begin
    cur_write = lat_write;
    cur_addr  = lat_addr;
    cur_wdata = lat_wdata;
    if (state == IDLE) begin
      cur_write = req_write;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
    end
  end

  assign cur_err = ((cur_addr & ALIGN_MASK) != 32'd0) ||
                   ((cur_addr >> (WIDTH + DEPTH)) != 32'd0);
  assign idx     = cur_addr[WIDTH+DEPTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt       <= CNT_INIT;
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (fire) begin
        err_q   <= cur_err;
        rdata_q <= (cur_write || cur_err) ? 32'd0 : mem[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire && !reset && cur_write && !cur_err) mem[idx] <= cur_wdata;
  end

  assign resp_rdata = (state == RESP) ? rdata_q : 32'd0;
  assign resp_err   = (state == RESP) & err_q;

endmodule
